// File: rtl/sized_deque_pkg.sv
// sized_deque_pkg: command opcodes shared by the deque and its users
package sized_deque_pkg;
   localparam int OP_W = 3;
   typedef enum logic [OP_W-1:0] {
      OP_NOP        = 3'd0,
      OP_PUSH_BACK  = 3'd1,
      OP_PUSH_FRONT = 3'd2,
      OP_POP_FRONT  = 3'd3,
      OP_POP_BACK   = 3'd4,
      OP_WRITE      = 3'd5,
      OP_READ       = 3'd6,
      OP_CLEAR      = 3'd7
   } deque_op_e;
endpackage

// File: rtl/sized_deque_idx_map.sv
// deque_idx_map: logical index to physical slot, (head + idx) mod DEPTH
module deque_idx_map #(
   parameter int DEPTH = 5,
   parameter int PTR_W = 3,
   parameter int CNT_W = 3
) (
   input  logic [PTR_W-1:0] head,
   input  logic [CNT_W-1:0] idx,
   output logic [PTR_W-1:0] addr
);
   logic [CNT_W:0] sum;
   always_comb begin
      sum  = (CNT_W+1)'(head) + (CNT_W+1)'(idx);
      addr = PTR_W'(sum >= (CNT_W+1)'(DEPTH) ? sum - (CNT_W+1)'(DEPTH) : sum);
   end
endmodule

// File: rtl/sized_deque.sv
// sized_deque: bounded double-ended queue on a circular buffer with indexed access
module sized_deque
   import sized_deque_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 5,
   localparam int CNT_W     = $clog2(DEPTH+1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   input  deque_op_e             cmd_op,
   input  logic [DATA_WIDTH-1:0] cmd_data,
   input  logic [CNT_W-1:0]      cmd_idx,
   output logic                  cmd_ready,
   output logic [DATA_WIDTH-1:0] front_data,
   output logic [DATA_WIDTH-1:0] back_data,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic [CNT_W-1:0]      size,
   output logic                  full,
   output logic                  empty,
   output logic                  err
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] LAST     = PTR_W'(DEPTH-1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] head, tail, head_inc, head_dec, tail_inc, tail_dec;
   logic [PTR_W-1:0] cmd_addr, back_addr, waddr;
   logic [CNT_W-1:0] count, back_idx;
   logic accept, is_push, is_pop, is_idx, bad, ok, we;

   deque_idx_map #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)) u_cmd_map (
      .head(head), .idx(cmd_idx), .addr(cmd_addr)
   );
   deque_idx_map #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)) u_back_map (
      .head(head), .idx(back_idx), .addr(back_addr)
   );

   assign cmd_ready  = !rd_valid;
   assign size       = count;
   assign full       = count == FULL_CNT;
   assign empty      = count == '0;
   assign back_idx   = count - CNT_W'(1);
   assign front_data = empty ? '0 : mem[head];
   assign back_data  = empty ? '0 : mem[back_addr];

   always_comb begin
      accept   = cmd_valid && cmd_ready;
      is_push  = cmd_op == OP_PUSH_BACK || cmd_op == OP_PUSH_FRONT;
      is_pop   = cmd_op == OP_POP_FRONT || cmd_op == OP_POP_BACK;
      is_idx   = cmd_op == OP_WRITE || cmd_op == OP_READ;
      bad      = accept && ((is_push && full) || (is_pop && empty) || (is_idx && cmd_idx >= count));
      ok       = accept && !bad;
      head_inc = head == LAST ? '0 : head + 1'b1;
      head_dec = head == '0 ? LAST : head - 1'b1;
      tail_inc = tail == LAST ? '0 : tail + 1'b1;
      tail_dec = tail == '0 ? LAST : tail - 1'b1;
      we       = ok && (is_push || cmd_op == OP_WRITE);
      waddr    = cmd_op == OP_PUSH_BACK ? tail : cmd_op == OP_PUSH_FRONT ? head_dec : cmd_addr;
   end

   always_ff @(posedge clk)
      if (we && !rst) mem[waddr] <= cmd_data;

   always_ff @(posedge clk)
      if (rst) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         err      <= 1'b0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         head     <= ok && cmd_op == OP_CLEAR ? '0 :
                     ok && cmd_op == OP_PUSH_FRONT ? head_dec :
                     ok && cmd_op == OP_POP_FRONT ? head_inc : head;
         tail     <= ok && cmd_op == OP_CLEAR ? '0 :
                     ok && cmd_op == OP_PUSH_BACK ? tail_inc :
                     ok && cmd_op == OP_POP_BACK ? tail_dec : tail;
         count    <= ok && cmd_op == OP_CLEAR ? '0 :
                     ok && is_push ? count + 1'b1 :
                     ok && is_pop ? count - 1'b1 : count;
         err      <= ok && cmd_op == OP_CLEAR ? 1'b0 : bad ? 1'b1 : err;
         rd_valid <= ok && cmd_op == OP_READ;
         rd_data  <= ok && cmd_op == OP_READ ? mem[cmd_addr] : rd_data;
      end
endmodule

// File: tb/tb_sized_deque.sv
// tb_sized_deque: directed and random checks of sized_deque against a queue model
module tb_sized_deque;
   import sized_deque_pkg::*;
   localparam int DW    = 32;
   localparam int DEPTH = 5;
   localparam int CNT_W = $clog2(DEPTH+1);

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic cmd_valid = 1'b0;
   deque_op_e cmd_op = OP_NOP;
   logic [DW-1:0] cmd_data = '0;
   logic [CNT_W-1:0] cmd_idx = '0;
   logic cmd_ready, rd_valid, full, empty, err;
   logic [DW-1:0] front_data, back_data, rd_data;
   logic [CNT_W-1:0] size;

   int tests = 0;
   int fails = 0;

   logic [31:0] q[$];
   logic err_m = 1'b0;
   logic rdv_m = 1'b0;
   logic [31:0] rd_m = '0;

   sized_deque #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
      .cmd_data(cmd_data), .cmd_idx(cmd_idx), .cmd_ready(cmd_ready),
      .front_data(front_data), .back_data(back_data), .rd_data(rd_data),
      .rd_valid(rd_valid), .size(size), .full(full), .empty(empty), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("size", 32'(size), q.size());
      chk("front", front_data, q.size() != 0 ? q[0] : 32'd0);
      chk("back", back_data, q.size() != 0 ? q[$] : 32'd0);
      chk("err", 32'(err), 32'(err_m));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("full", 32'(full), 32'(q.size() == DEPTH));
      chk("rd_valid", 32'(rd_valid), 32'(rdv_m));
      chk("cmd_ready", 32'(cmd_ready), 32'(!rdv_m));
      if (rdv_m) chk("rd_data", rd_data, rd_m);
   endtask

   task automatic model_reset();
      q.delete();
      err_m = 1'b0;
      rdv_m = 1'b0;
   endtask

   task automatic step(input deque_op_e op, input logic [31:0] d, input int idx, input logic v = 1'b1);
      logic acc;
      cmd_valid = v;
      cmd_op    = op;
      cmd_data  = d;
      cmd_idx   = CNT_W'(idx);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      acc   = v && !rdv_m;
      rdv_m = 1'b0;
      if (acc)
         case (op)
            OP_PUSH_BACK:  if (q.size() < DEPTH) q.push_back(d); else err_m = 1'b1;
            OP_PUSH_FRONT: if (q.size() < DEPTH) q.push_front(d); else err_m = 1'b1;
            OP_POP_FRONT:  if (q.size() > 0) void'(q.pop_front()); else err_m = 1'b1;
            OP_POP_BACK:   if (q.size() > 0) void'(q.pop_back()); else err_m = 1'b1;
            OP_WRITE:      if (idx < q.size()) q[idx] = d; else err_m = 1'b1;
            OP_READ:       if (idx < q.size()) begin rd_m = q[idx]; rdv_m = 1'b1; end else err_m = 1'b1;
            OP_CLEAR:      begin q.delete(); err_m = 1'b0; end
            default: ;
         endcase
      check_all();
   endtask

   task automatic reset_with(input deque_op_e op, input int idx);
      rst = 1'b1;
      cmd_valid = 1'b1;
      cmd_op = op;
      cmd_data = 32'd7;
      cmd_idx = CNT_W'(idx);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cmd_valid = 1'b0;
      model_reset();
      check_all();
   endtask

   initial begin
      deque_op_e op;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      check_all();
      chk("rst_rd_data", rd_data, 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);

      step(OP_PUSH_BACK, 10, 0);
      step(OP_PUSH_BACK, 20, 0);
      step(OP_PUSH_BACK, 30, 0);
      chk("basic_size", 32'(size), 32'd3);
      chk("basic_front", front_data, 32'd10);
      chk("basic_back", back_data, 32'd30);
      chk("basic_err", 32'(err), 32'd0);

      step(OP_PUSH_FRONT, 5, 0);
      step(OP_POP_BACK, 0, 0);
      chk("pf_front", front_data, 32'd5);
      chk("pf_back", back_data, 32'd20);
      chk("pf_size", 32'(size), 32'd3);

      step(OP_PUSH_BACK, 40, 0);
      step(OP_PUSH_BACK, 50, 0);
      step(OP_PUSH_BACK, 99, 0);
      chk("ovf_full", 32'(full), 32'd1);
      chk("ovf_size", 32'(size), 32'd5);
      chk("ovf_err", 32'(err), 32'd1);
      for (int i = 0; i < DEPTH; i++) begin
         step(OP_READ, 0, i);
         step(OP_NOP, 0, 0);
      end
      step(OP_CLEAR, 0, 0);
      chk("clr_size", 32'(size), 32'd0);
      chk("clr_err", 32'(err), 32'd0);

      step(OP_POP_FRONT, 0, 0);
      chk("unf_err", 32'(err), 32'd1);
      step(OP_READ, 0, 0);
      chk("unf_rd_valid", 32'(rd_valid), 32'd0);

      step(OP_CLEAR, 0, 0);
      step(OP_PUSH_FRONT, 100, 0);
      step(OP_PUSH_BACK, 200, 0);
      step(OP_PUSH_BACK, 300, 0);
      step(OP_READ, 0, 2);
      chk("wrap_rd_valid", 32'(rd_valid), 32'd1);
      chk("wrap_rd_data", rd_data, 32'd300);
      chk("wrap_ready", 32'(cmd_ready), 32'd0);
      step(OP_WRITE, 999, 1);
      step(OP_WRITE, 250, 1);
      step(OP_READ, 0, 1);
      chk("wrap_rd_250", rd_data, 32'd250);
      chk("wrap_err", 32'(err), 32'd0);

      reset_with(OP_PUSH_BACK, 0);
      chk("rstcmd_size", 32'(size), 32'd0);
      chk("rstcmd_empty", 32'(empty), 32'd1);
      step(OP_PUSH_BACK, 1, 0);
      reset_with(OP_READ, 0);
      chk("rstread_rd_valid", 32'(rd_valid), 32'd0);

      for (int n = 0; n < 400; n++) begin
         op = deque_op_e'($urandom_range(0, 7));
         if (op == OP_CLEAR && $urandom_range(0, 9) != 0) op = OP_PUSH_BACK;
         step(op, $urandom, $urandom_range(0, DEPTH), $urandom_range(0, 9) != 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
